// File: rtl/axi_buffer_if.sv
// axi_channel: bundle of the five AXI channels (AW, W, AR, R, B) between one
// master and one slave.
//   modport master : drives AW/W/AR payload+valid and R/B ready.
//   modport slave  : drives AW/W/AR ready and R/B payload+valid.
interface axi_channel #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_USER_WIDTH = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int R_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1
);
  logic [ID_WIDTH-1:0]      aw_id;
  logic [ADDR_WIDTH-1:0]    aw_addr;
  logic [7:0]               aw_len;
  logic [2:0]               aw_size;
  logic [1:0]               aw_burst;
  logic                     aw_lock;
  logic [3:0]               aw_cache;
  logic [2:0]               aw_prot;
  logic [3:0]               aw_qos;
  logic [3:0]               aw_region;
  logic [AW_USER_WIDTH-1:0] aw_user;
  logic                     aw_valid;
  logic                     aw_ready;

  logic [DATA_WIDTH-1:0]    w_data;
  logic [DATA_WIDTH/8-1:0]  w_strb;
  logic                     w_last;
  logic [W_USER_WIDTH-1:0]  w_user;
  logic                     w_valid;
  logic                     w_ready;

  logic [ID_WIDTH-1:0]      ar_id;
  logic [ADDR_WIDTH-1:0]    ar_addr;
  logic [7:0]               ar_len;
  logic [2:0]               ar_size;
  logic [1:0]               ar_burst;
  logic                     ar_lock;
  logic [3:0]               ar_cache;
  logic [2:0]               ar_prot;
  logic [3:0]               ar_qos;
  logic [3:0]               ar_region;
  logic [AR_USER_WIDTH-1:0] ar_user;
  logic                     ar_valid;
  logic                     ar_ready;

  logic [ID_WIDTH-1:0]      r_id;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [1:0]               r_resp;
  logic                     r_last;
  logic [R_USER_WIDTH-1:0]  r_user;
  logic                     r_valid;
  logic                     r_ready;

  logic [ID_WIDTH-1:0]      b_id;
  logic [1:0]               b_resp;
  logic [B_USER_WIDTH-1:0]  b_user;
  logic                     b_valid;
  logic                     b_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/axi_buffer.sv
// axi_buffer: one independent FIFO per AXI channel between an upstream master
// and a downstream slave. Depth 0 on a channel is a combinational wire-through;
// depth >= 1 registers valid, ready and payload on that channel.
//   clk    : single clock for all channels
//   rstn   : asynchronous active-low reset
//   master : upstream side (this block is the slave toward it)
//   slave  : downstream side (this block is the master toward it)
// AW, W, AR flow master -> slave; R, B flow slave -> master.

// axi_buffer_fifo: single-channel valid/ready FIFO with a packed payload.
module axi_buffer_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  if (DEPTH == 0) begin : g_pass
    // Clock and reset have no role in a pass-through channel.
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk & rstn;

    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             push_s, pop_s;

    // Handshakes use only the registered ready/valid, so no input reaches an output.
    assign push_s = in_valid & in_ready_q;
    assign pop_s  = out_valid_q & out_ready;

    // Next-state for pointers, occupancy and the registered handshake flags.
    always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;

      // Pointers wrap explicitly so DEPTH need not be a power of two.
      if (push_s) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      in_ready_d  = (count_d < DEPTH_C);
      out_valid_d = (count_d != {CW{1'b0}});
    end

    // Control state; readies come up on the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr_q    <= {PW{1'b0}};
        rd_ptr_q    <= {PW{1'b0}};
        count_q     <= {CW{1'b0}};
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        in_ready_q  <= in_ready_d;
        out_valid_q <= out_valid_d;
      end
    end

    // Payload storage; an occupied slot is never written, which keeps the output stable.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem_q[rd_ptr_q];
  end
endmodule

module axi_buffer #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_USER_WIDTH = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int R_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1,
  parameter int AW_DEPTH      = 2,
  parameter int W_DEPTH       = 2,
  parameter int AR_DEPTH      = 2,
  parameter int R_DEPTH       = 2,
  parameter int B_DEPTH       = 2
) (
  input logic        clk,
  input logic        rstn,
  axi_channel.slave  master,
  axi_channel.master slave
);
  // len(8) size(3) burst(2) lock(1) cache(4) prot(3) qos(4) region(4)
  localparam int AX_FIXED = 29;
  localparam int AW_W = ID_WIDTH + ADDR_WIDTH + AX_FIXED + AW_USER_WIDTH;
  localparam int AR_W = ID_WIDTH + ADDR_WIDTH + AX_FIXED + AR_USER_WIDTH;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + W_USER_WIDTH;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1 + R_USER_WIDTH;
  localparam int B_W  = ID_WIDTH + 2 + B_USER_WIDTH;

  if (AW_DEPTH < 0 || W_DEPTH < 0 || AR_DEPTH < 0 || R_DEPTH < 0 || B_DEPTH < 0) begin : g_bad_depth
    $fatal(1, "axi_buffer: channel depths must be >= 0");
  end

  if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data
    $fatal(1, "axi_buffer: DATA_WIDTH must be a power of 2 in [8,1024]");
  end

  logic [AW_W-1:0] aw_in_s, aw_out_s;
  logic [W_W-1:0]  w_in_s,  w_out_s;
  logic [AR_W-1:0] ar_in_s, ar_out_s;
  logic [R_W-1:0]  r_in_s,  r_out_s;
  logic [B_W-1:0]  b_in_s,  b_out_s;

  assign aw_in_s = {master.aw_id, master.aw_addr, master.aw_len, master.aw_size, master.aw_burst,
                    master.aw_lock, master.aw_cache, master.aw_prot, master.aw_qos,
                    master.aw_region, master.aw_user};
  assign {slave.aw_id, slave.aw_addr, slave.aw_len, slave.aw_size, slave.aw_burst,
          slave.aw_lock, slave.aw_cache, slave.aw_prot, slave.aw_qos,
          slave.aw_region, slave.aw_user} = aw_out_s;

  assign w_in_s = {master.w_data, master.w_strb, master.w_last, master.w_user};
  assign {slave.w_data, slave.w_strb, slave.w_last, slave.w_user} = w_out_s;

  assign ar_in_s = {master.ar_id, master.ar_addr, master.ar_len, master.ar_size, master.ar_burst,
                    master.ar_lock, master.ar_cache, master.ar_prot, master.ar_qos,
                    master.ar_region, master.ar_user};
  assign {slave.ar_id, slave.ar_addr, slave.ar_len, slave.ar_size, slave.ar_burst,
          slave.ar_lock, slave.ar_cache, slave.ar_prot, slave.ar_qos,
          slave.ar_region, slave.ar_user} = ar_out_s;

  assign r_in_s = {slave.r_id, slave.r_data, slave.r_resp, slave.r_last, slave.r_user};
  assign {master.r_id, master.r_data, master.r_resp, master.r_last, master.r_user} = r_out_s;

  assign b_in_s = {slave.b_id, slave.b_resp, slave.b_user};
  assign {master.b_id, master.b_resp, master.b_user} = b_out_s;

  axi_buffer_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AW_W)) u_aw (
    .clk(clk), .rstn(rstn),
    .in_valid(master.aw_valid), .in_ready(master.aw_ready), .in_data(aw_in_s),
    .out_valid(slave.aw_valid), .out_ready(slave.aw_ready), .out_data(aw_out_s)
  );

  axi_buffer_fifo #(.DEPTH(W_DEPTH), .WIDTH(W_W)) u_w (
    .clk(clk), .rstn(rstn),
    .in_valid(master.w_valid), .in_ready(master.w_ready), .in_data(w_in_s),
    .out_valid(slave.w_valid), .out_ready(slave.w_ready), .out_data(w_out_s)
  );

  axi_buffer_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AR_W)) u_ar (
    .clk(clk), .rstn(rstn),
    .in_valid(master.ar_valid), .in_ready(master.ar_ready), .in_data(ar_in_s),
    .out_valid(slave.ar_valid), .out_ready(slave.ar_ready), .out_data(ar_out_s)
  );

  axi_buffer_fifo #(.DEPTH(R_DEPTH), .WIDTH(R_W)) u_r (
    .clk(clk), .rstn(rstn),
    .in_valid(slave.r_valid), .in_ready(slave.r_ready), .in_data(r_in_s),
    .out_valid(master.r_valid), .out_ready(master.r_ready), .out_data(r_out_s)
  );

  axi_buffer_fifo #(.DEPTH(B_DEPTH), .WIDTH(B_W)) u_b (
    .clk(clk), .rstn(rstn),
    .in_valid(slave.b_valid), .in_ready(slave.b_ready), .in_data(b_in_s),
    .out_valid(master.b_valid), .out_ready(master.b_ready), .out_data(b_out_s)
  );
endmodule

// File: tb/tb_axi_buffer.sv
// Testbench for axi_buffer: AW depth 4, W depth 2, AR depth 3, R depth 0
// (pass-through), B depth 1. Expected behaviour comes from per-channel
// reference queues and the latency/throughput rules of the buffer.
module tb_axi_buffer;
  localparam int AWD = 4;
  localparam int WD  = 2;
  localparam int ARD = 3;
  localparam int WP  = 64 + 8 + 1 + 1;
  localparam int AWP = 8 + 48 + 29 + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  axi_channel #(.ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64)) m_if ();
  axi_channel #(.ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64)) s_if ();

  axi_buffer #(
    .ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64),
    .AW_USER_WIDTH(1), .AR_USER_WIDTH(1), .W_USER_WIDTH(1), .R_USER_WIDTH(1), .B_USER_WIDTH(1),
    .AW_DEPTH(AWD), .W_DEPTH(WD), .AR_DEPTH(ARD), .R_DEPTH(0), .B_DEPTH(1)
  ) dut (
    .clk(clk), .rstn(rstn), .master(m_if), .slave(s_if)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    {m_if.aw_id, m_if.aw_addr, m_if.aw_len, m_if.aw_size, m_if.aw_burst, m_if.aw_lock,
     m_if.aw_cache, m_if.aw_prot, m_if.aw_qos, m_if.aw_region, m_if.aw_user} = '0;
    {m_if.ar_id, m_if.ar_addr, m_if.ar_len, m_if.ar_size, m_if.ar_burst, m_if.ar_lock,
     m_if.ar_cache, m_if.ar_prot, m_if.ar_qos, m_if.ar_region, m_if.ar_user} = '0;
    {m_if.w_data, m_if.w_strb, m_if.w_last, m_if.w_user} = '0;
    {s_if.r_id, s_if.r_data, s_if.r_resp, s_if.r_last, s_if.r_user} = '0;
    {s_if.b_id, s_if.b_resp, s_if.b_user} = '0;
    m_if.aw_valid = 1'b0; m_if.w_valid = 1'b0; m_if.ar_valid = 1'b0;
    s_if.r_valid = 1'b0; s_if.b_valid = 1'b0;
    s_if.aw_ready = 1'b0; s_if.w_ready = 1'b0; s_if.ar_ready = 1'b0;
    m_if.r_ready = 1'b0; m_if.b_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] v, r;
    rstn = 1'b0;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      v = {s_if.aw_valid, s_if.w_valid, s_if.ar_valid, m_if.b_valid};
      r = {m_if.aw_ready, m_if.w_ready, m_if.ar_ready, s_if.b_ready};
      checks++;
      if (v !== 4'b0000) begin errors++; $display("FAIL reset_valids got %b exp 0000", v); end
      checks++;
      if (r !== 4'b0000) begin errors++; $display("FAIL reset_readies got %b exp 0000", r); end
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (m_if.aw_ready !== 1'b0) begin errors++; $display("FAIL release_aw_ready_early got %b exp 0", m_if.aw_ready); end
    @(posedge clk); #1;
    r = {m_if.aw_ready, m_if.w_ready, m_if.ar_ready, s_if.b_ready};
    checks++;
    if (r !== 4'b1111) begin errors++; $display("FAIL release_readies got %b exp 1111", r); end
    v = {s_if.aw_valid, s_if.w_valid, s_if.ar_valid, m_if.b_valid};
    checks++;
    if (v !== 4'b0000) begin errors++; $display("FAIL release_valids got %b exp 0000", v); end
  endtask

  task automatic test_w_stream();
    logic exp_v;
    s_if.w_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      m_if.w_valid = (c < 16);
      m_if.w_data  = 64'(c);
      m_if.w_strb  = 8'hFF;
      m_if.w_last  = (c == 15);
      m_if.w_user  = 1'(c);
      #1;
      checks++;
      if (m_if.w_ready !== 1'b1) begin errors++; $display("FAIL w_stream_ready c=%0d got %b exp 1", c, m_if.w_ready); end
      exp_v = (c >= 1 && c <= 16);
      checks++;
      if (s_if.w_valid !== exp_v) begin errors++; $display("FAIL w_stream_valid c=%0d got %b exp %b", c, s_if.w_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (s_if.w_data !== 64'(c - 1) || s_if.w_last !== (c == 16))
          begin errors++; $display("FAIL w_stream_beat c=%0d got data=%0d last=%b exp data=%0d last=%b", c, s_if.w_data, s_if.w_last, c - 1, (c == 16)); end
      end
    end
    m_if.w_valid = 1'b0;
    s_if.w_ready = 1'b0;
  endtask

  task automatic test_w_random();
    logic [WP-1:0] q[$];
    logic [WP-1:0] pay, got;
    logic exp_ready, exp_valid, push, pop;
    logic acc_prev = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!m_if.w_valid || acc_prev) begin
        if (c < 290) begin
          m_if.w_valid = ($urandom_range(0, 3) != 0);
          pay = WP'({$urandom(), $urandom(), $urandom()});
          {m_if.w_data, m_if.w_strb, m_if.w_last, m_if.w_user} = pay;
        end else begin
          m_if.w_valid = 1'b0;
        end
      end
      s_if.w_ready = (c >= 290) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      exp_ready = (q.size() < WD);
      exp_valid = (q.size() > 0);
      checks++;
      if (m_if.w_ready !== exp_ready) begin errors++; $display("FAIL w_rand_ready c=%0d got %b exp %b", c, m_if.w_ready, exp_ready); end
      checks++;
      if (s_if.w_valid !== exp_valid) begin errors++; $display("FAIL w_rand_valid c=%0d got %b exp %b", c, s_if.w_valid, exp_valid); end
      if (exp_valid) begin
        got = {s_if.w_data, s_if.w_strb, s_if.w_last, s_if.w_user};
        checks++;
        if (got !== q[0]) begin errors++; $display("FAIL w_rand_data c=%0d got %h exp %h", c, got, q[0]); end
      end
      pop  = exp_valid && s_if.w_ready;
      push = m_if.w_valid && exp_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({m_if.w_data, m_if.w_strb, m_if.w_last, m_if.w_user});
      acc_prev = push;
    end
    m_if.w_valid = 1'b0;
    s_if.w_ready = 1'b0;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL w_rand_drain got %0d left exp 0", q.size()); end
  endtask

  task automatic test_aw_random();
    logic [AWP-1:0] q[$];
    logic [AWP-1:0] pay, got;
    logic exp_ready, exp_valid, push, pop;
    logic acc_prev = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!m_if.aw_valid || acc_prev) begin
        if (c < 290) begin
          m_if.aw_valid = ($urandom_range(0, 2) != 0);
          pay = AWP'({$urandom(), $urandom(), $urandom()});
          {m_if.aw_id, m_if.aw_addr, m_if.aw_len, m_if.aw_size, m_if.aw_burst, m_if.aw_lock,
           m_if.aw_cache, m_if.aw_prot, m_if.aw_qos, m_if.aw_region, m_if.aw_user} = pay;
        end else begin
          m_if.aw_valid = 1'b0;
        end
      end
      s_if.aw_ready = (c >= 290) ? 1'b1 : ($urandom_range(0, 3) == 0);
      #1;
      exp_ready = (q.size() < AWD);
      exp_valid = (q.size() > 0);
      checks++;
      if (m_if.aw_ready !== exp_ready) begin errors++; $display("FAIL aw_rand_ready c=%0d got %b exp %b", c, m_if.aw_ready, exp_ready); end
      checks++;
      if (s_if.aw_valid !== exp_valid) begin errors++; $display("FAIL aw_rand_valid c=%0d got %b exp %b", c, s_if.aw_valid, exp_valid); end
      if (exp_valid) begin
        got = {s_if.aw_id, s_if.aw_addr, s_if.aw_len, s_if.aw_size, s_if.aw_burst, s_if.aw_lock,
               s_if.aw_cache, s_if.aw_prot, s_if.aw_qos, s_if.aw_region, s_if.aw_user};
        checks++;
        if (got !== q[0]) begin errors++; $display("FAIL aw_rand_data c=%0d got %h exp %h", c, got, q[0]); end
      end
      pop  = exp_valid && s_if.aw_ready;
      push = m_if.aw_valid && exp_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({m_if.aw_id, m_if.aw_addr, m_if.aw_len, m_if.aw_size, m_if.aw_burst,
                             m_if.aw_lock, m_if.aw_cache, m_if.aw_prot, m_if.aw_qos,
                             m_if.aw_region, m_if.aw_user});
      acc_prev = push;
    end
    m_if.aw_valid = 1'b0;
    s_if.aw_ready = 1'b0;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL aw_rand_drain got %0d left exp 0", q.size()); end
  endtask

  task automatic test_ar_backpressure();
    logic [47:0] q[$];
    logic [47:0] exp_addr;
    logic exp_ready, exp_valid, push, pop;
    int idx = 0;
    int recv = 0;
    s_if.ar_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 8) s_if.ar_ready = 1'b1;
      m_if.ar_valid = (idx < 5);
      m_if.ar_addr  = 48'h100 + 48'(idx) * 48'h10;
      m_if.ar_id    = 8'(idx + 3);
      m_if.ar_len   = 8'($urandom());
      #1;
      exp_ready = (q.size() < ARD);
      exp_valid = (q.size() > 0);
      checks++;
      if (m_if.ar_ready !== exp_ready) begin errors++; $display("FAIL ar_bp_ready c=%0d got %b exp %b", c, m_if.ar_ready, exp_ready); end
      checks++;
      if (s_if.ar_valid !== exp_valid) begin errors++; $display("FAIL ar_bp_valid c=%0d got %b exp %b", c, s_if.ar_valid, exp_valid); end
      if (exp_valid) begin
        exp_addr = 48'h100 + 48'(recv) * 48'h10;
        checks++;
        if (s_if.ar_addr !== exp_addr || s_if.ar_addr !== q[0] || s_if.ar_id !== 8'(recv + 3))
          begin errors++; $display("FAIL ar_bp_order c=%0d got addr=%h id=%0d exp addr=%h id=%0d", c, s_if.ar_addr, s_if.ar_id, exp_addr, recv + 3); end
      end
      if (c == 7) begin
        checks++;
        if (idx != 3 || m_if.ar_ready !== 1'b0) begin errors++; $display("FAIL ar_bp_full accepted=%0d ready=%b exp accepted=3 ready=0", idx, m_if.ar_ready); end
      end
      pop  = exp_valid && s_if.ar_ready;
      push = m_if.ar_valid && exp_ready;
      if (pop) begin void'(q.pop_front()); recv++; end
      if (push) begin q.push_back(m_if.ar_addr); idx++; end
    end
    m_if.ar_valid = 1'b0;
    s_if.ar_ready = 1'b0;
    checks++;
    if (recv != 5) begin errors++; $display("FAIL ar_bp_count got %0d exp 5", recv); end
  endtask

  task automatic test_b_depth1();
    logic [7:0] q[$];
    logic exp_ready, exp_valid, push, pop;
    int idx = 0;
    int recv = 0;
    m_if.b_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      s_if.b_valid = (idx < 8);
      s_if.b_id    = 8'(idx);
      s_if.b_resp  = 2'(idx);
      s_if.b_user  = 1'(idx);
      #1;
      exp_ready = (q.size() < 1);
      exp_valid = (q.size() > 0);
      checks++;
      if (s_if.b_ready !== exp_ready) begin errors++; $display("FAIL b_d1_ready c=%0d got %b exp %b", c, s_if.b_ready, exp_ready); end
      checks++;
      if (m_if.b_valid !== exp_valid) begin errors++; $display("FAIL b_d1_valid c=%0d got %b exp %b", c, m_if.b_valid, exp_valid); end
      pop  = exp_valid && m_if.b_ready;
      push = s_if.b_valid && exp_ready;
      if (pop) begin
        checks++;
        if (m_if.b_id !== q[0] || m_if.b_id !== 8'(recv) || c != 2 * recv + 1)
          begin errors++; $display("FAIL b_d1_beat c=%0d got id=%0d exp id=%0d at cycle %0d", c, m_if.b_id, recv, 2 * recv + 1); end
        void'(q.pop_front());
        recv++;
      end
      if (push) begin q.push_back(s_if.b_id); idx++; end
    end
    s_if.b_valid = 1'b0;
    m_if.b_ready = 1'b0;
    checks++;
    if (recv != 8) begin errors++; $display("FAIL b_d1_count got %0d exp 8", recv); end
  endtask

  task automatic test_r_passthrough();
    logic [63:0] d;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        s_if.r_valid = 1'b1; d = 64'hDEAD; s_if.r_last = 1'b1; m_if.r_ready = 1'b1;
      end else begin
        s_if.r_valid = 1'($urandom()); d = {$urandom(), $urandom()};
        s_if.r_last = 1'($urandom()); m_if.r_ready = 1'($urandom());
      end
      s_if.r_data = d;
      s_if.r_id   = 8'($urandom());
      s_if.r_resp = 2'($urandom());
      #2;
      checks++;
      if (m_if.r_valid !== s_if.r_valid || m_if.r_data !== d || m_if.r_last !== s_if.r_last ||
          m_if.r_id !== s_if.r_id || m_if.r_resp !== s_if.r_resp)
        begin errors++; $display("FAIL r_pass_fwd c=%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b", c, m_if.r_valid, m_if.r_data, m_if.r_last, s_if.r_valid, d, s_if.r_last); end
      // Toggle ready away from any clock edge; slave-side ready must follow at once.
      m_if.r_ready = ~m_if.r_ready;
      #1;
      checks++;
      if (s_if.r_ready !== m_if.r_ready) begin errors++; $display("FAIL r_pass_ready c=%0d got %b exp %b", c, s_if.r_ready, m_if.r_ready); end
    end
    s_if.r_valid = 1'b0;
    m_if.r_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    s_if.aw_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m_if.aw_valid = 1'b1;
      m_if.aw_id    = 8'(i + 9);
      m_if.aw_addr  = 48'h2000 + 48'(i);
    end
    @(negedge clk);
    m_if.aw_valid = 1'b0;
    #1;
    checks++;
    if (s_if.aw_valid !== 1'b1 || m_if.aw_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got valid=%b ready=%b exp 1 1", s_if.aw_valid, m_if.aw_ready); end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (s_if.aw_valid !== 1'b0 || m_if.aw_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_async got valid=%b ready=%b exp 0 0", s_if.aw_valid, m_if.aw_ready); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    s_if.aw_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++;
      if (s_if.aw_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale c=%0d got %b exp 0", c, s_if.aw_valid); end
    end
    s_if.aw_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_w_stream();
    test_w_random();
    test_aw_random();
    test_ar_backpressure();
    test_b_depth1();
    test_r_passthrough();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
